sparse_col_feeder: RTL and testbench

SPARSE_COL_FEEDER -- requirements
Module: sparse_col_feeder

---
 rtl/sparse_col_feeder_pkg.sv | 11 +
 rtl/sparse_col_feeder_sync_fifo.sv | 47 ++++
 rtl/sparse_col_feeder.sv | 157 +++++++++++++++
 tb/tb_sparse_col_feeder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sparse_col_feeder_pkg.sv
// sparse_col_feeder_pkg: shared widths, FSM states and entry layout for the sparse column feeder
package sparse_col_feeder_pkg;
   localparam int DATA_W = 32;
   localparam int IDX_W = 12;
   typedef enum logic [2:0] {IDLE, GET_VEC, FILL1, FILL2, EMIT, DONE} state_t;
   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic [IDX_W-1:0]  row_idx;
      logic              last;
   } entry_t;
endpackage

// File: rtl/sparse_col_feeder_sync_fifo.sv
// sync_fifo: fall-through FIFO; a push is refused whenever full, even alongside a pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   // Occupancy flags and pointer/level updates
   always_comb begin
      full = cnt_q == (AW+1)'(DEPTH);
      empty = cnt_q == '0;
      do_push = push && !full;
      do_pop = pop && !empty;
      wr_d = wr_q + AW'(do_push);
      rd_d = rd_q + AW'(do_pop);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout = mem_q[rd_q];
   end
   // Pointer and level state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // Storage needs no reset; the level decides what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end
endmodule

// File: rtl/sparse_col_feeder.sv
// sparse_col_feeder: packs each column's nonzeros into two-lane pairs with the column's vector word
module sparse_col_feeder #(
   parameter int DATA_W = sparse_col_feeder_pkg::DATA_W,
   parameter int IDX_W = sparse_col_feeder_pkg::IDX_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [IDX_W-1:0]  col_count,
   input  logic              ent_valid,
   output logic              ent_ready,
   input  logic [DATA_W-1:0] ent_val,
   input  logic [IDX_W-1:0]  ent_rowIdx,
   input  logic              ent_last,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic [DATA_W-1:0] vec_data,
   output logic [DATA_W-1:0] val1,
   output logic [DATA_W-1:0] val2,
   output logic [IDX_W-1:0]  rowIdx1,
   output logic [IDX_W-1:0]  rowIdx2,
   output logic              tag1,
   output logic              tag2,
   output logic [DATA_W-1:0] vec,
   output logic              out_valid,
   output logic              busy,
   output logic              done,
   output logic [15:0]       pairs_emitted
);
   import sparse_col_feeder_pkg::*;
   localparam int EW = DATA_W + IDX_W + 1;
   state_t state_q, state_d;
   logic [IDX_W-1:0] cols_q, cols_d, col_q, col_d, r1_q, r1_d, r2_q, r2_d;
   logic [DATA_W-1:0] vec_q, vec_d, v1_q, v1_d, v2_q, v2_d;
   logic t2_q, t2_d, last_q, last_d, busy_q, busy_d, run_q;
   logic [15:0] cnt_q, cnt_d;
   logic fifo_full, fifo_empty, pop;
   logic [EW-1:0] head;
   logic [DATA_W-1:0] h_val;
   logic [IDX_W-1:0] h_row;
   logic h_last;
   assign {h_val, h_row, h_last} = head;
   assign ent_ready = run_q && !fifo_full;
   assign pop = !fifo_empty && (state_q == FILL1 || state_q == FILL2);
   sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(ent_valid && ent_ready),
      .din({ent_val, ent_rowIdx, ent_last}),
      .full(fifo_full),
      .pop(pop),
      .dout(head),
      .empty(fifo_empty)
   );
   // Lane outputs read as zero between issues; vec holds across the column
   always_comb begin
      out_valid = state_q == EMIT;
      val1 = out_valid ? v1_q : '0;
      val2 = out_valid ? v2_q : '0;
      rowIdx1 = out_valid ? r1_q : '0;
      rowIdx2 = out_valid ? r2_q : '0;
      tag1 = rowIdx1[0];
      tag2 = out_valid && t2_q;
      vec = vec_q;
      vec_ready = state_q == GET_VEC;
      done = state_q == DONE;
      busy = busy_q;
      pairs_emitted = cnt_q;
   end
   // Job sequencing: fetch vector, fill lane 1 then lane 2 (or pad), issue, advance column
   always_comb begin
      state_d = state_q;
      cols_d = cols_q;
      col_d = col_q;
      vec_d = vec_q;
      v1_d = v1_q;
      v2_d = v2_q;
      r1_d = r1_q;
      r2_d = r2_q;
      t2_d = t2_q;
      last_d = last_q;
      busy_d = busy_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (start) begin
            cnt_d = '0;
            col_d = '0;
            cols_d = col_count;
            busy_d = col_count != '0;
            state_d = col_count == '0 ? DONE : GET_VEC;
         end
         GET_VEC: if (vec_valid) begin
            vec_d = vec_data;
            state_d = FILL1;
         end
         FILL1: if (!fifo_empty) begin
            v1_d = h_val;
            r1_d = h_row;
            last_d = h_last;
            v2_d = '0;
            r2_d = '0;
            t2_d = 1'b1;
            state_d = h_last ? EMIT : FILL2;
         end
         FILL2: if (!fifo_empty) begin
            v2_d = h_val;
            r2_d = h_row;
            t2_d = h_row[0];
            last_d = h_last;
            state_d = EMIT;
         end
         EMIT: begin
            cnt_d = cnt_q + 16'(cnt_q != 16'hFFFF);
            col_d = last_q ? col_q + IDX_W'(1) : col_q;
            state_d = !last_q ? FILL1 : (col_q + IDX_W'(1) == cols_q) ? DONE : GET_VEC;
         end
         DONE: begin
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // State registers; run_q keeps ent_ready low until the first edge after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cols_q <= '0;
         col_q <= '0;
         vec_q <= '0;
         v1_q <= '0;
         v2_q <= '0;
         r1_q <= '0;
         r2_q <= '0;
         t2_q <= 1'b0;
         last_q <= 1'b0;
         busy_q <= 1'b0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cols_q <= cols_d;
         col_q <= col_d;
         vec_q <= vec_d;
         v1_q <= v1_d;
         v2_q <= v2_d;
         r1_q <= r1_d;
         r2_q <= r2_d;
         t2_q <= t2_d;
         last_q <= last_d;
         busy_q <= busy_d;
         cnt_q <= cnt_d;
         run_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sparse_col_feeder.sv
// tb_sparse_col_feeder: directed jobs with a scoreboard of expected lane pairs
module tb_sparse_col_feeder;
   localparam int DEPTH = 4;
   logic clk = 0, reset = 1, start = 0, ent_valid = 0, ent_last = 0, vec_valid = 0;
   logic [11:0] col_count = '0, ent_rowIdx = '0, rowIdx1, rowIdx2;
   logic [31:0] ent_val = '0, vec_data = '0, val1, val2, vec;
   logic ent_ready, vec_ready, tag1, tag2, out_valid, busy, done;
   logic [15:0] pairs_emitted;
   int checks = 0, errors = 0;
   typedef struct {
      logic [31:0] v1;
      logic [11:0] r1;
      logic t1;
      logic [31:0] v2;
      logic [11:0] r2;
      logic t2;
      logic [31:0] vc;
   } pair_t;
   pair_t sb[$];
   sparse_col_feeder #(.DATA_W(32), .IDX_W(12), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .col_count(col_count),
      .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_val(ent_val),
      .ent_rowIdx(ent_rowIdx), .ent_last(ent_last), .vec_valid(vec_valid),
      .vec_ready(vec_ready), .vec_data(vec_data), .val1(val1), .val2(val2),
      .rowIdx1(rowIdx1), .rowIdx2(rowIdx2), .tag1(tag1), .tag2(tag2), .vec(vec),
      .out_valid(out_valid), .busy(busy), .done(done), .pairs_emitted(pairs_emitted)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Every issued pair is compared against the oldest expected pair
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         chk("pair_expected", 64'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            pair_t e;
            e = sb.pop_front();
            chk("val1", val1, e.v1);
            chk("rowIdx1", rowIdx1, e.r1);
            chk("tag1", tag1, e.t1);
            chk("val2", val2, e.v2);
            chk("rowIdx2", rowIdx2, e.r2);
            chk("tag2", tag2, e.t2);
            chk("vec", vec, e.vc);
         end
      end
   end
   task automatic start_job(input logic [11:0] cc);
      @(negedge clk);
      start = 1;
      col_count = cc;
      @(negedge clk);
      start = 0;
   endtask
   task automatic push_ent(input logic [31:0] v, input logic [11:0] r, input logic l);
      int n = 0;
      ent_valid = 1;
      ent_val = v;
      ent_rowIdx = r;
      ent_last = l;
      while (!ent_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("ent_handshake", ent_ready, 1);
      @(negedge clk);
   endtask
   task automatic give_vec(input logic [31:0] d);
      int n = 0;
      vec_valid = 1;
      vec_data = d;
      while (!vec_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("vec_handshake", vec_ready, 1);
      @(negedge clk);
      vec_valid = 0;
   endtask
   task automatic wait_done(input logic [15:0] pairs);
      int n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
      chk("pairs_emitted", pairs_emitted, pairs);
      chk("sb_drained", 64'(sb.size()), 0);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_after_done", busy, 0);
   endtask
   initial begin
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ent_ready", ent_ready, 0);
      chk("rst_vec_ready", vec_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pairs", pairs_emitted, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("ready_after_rst", ent_ready, 1);
      // single pair with tags from row parity
      start_job(1);
      chk("busy_on_start", busy, 1);
      chk("vec_ready_getvec", vec_ready, 1);
      push_ent(32'h3F800000, 4, 0);
      push_ent(32'h40000000, 5, 1);
      ent_valid = 0;
      sb.push_back('{32'h3F800000, 4, 0, 32'h40000000, 5, 1, 32'h40400000});
      give_vec(32'h40400000);
      wait_done(1);
      // odd entry count pads lane 2
      start_job(1);
      push_ent(32'h40800000, 2, 0);
      push_ent(32'h40A00000, 3, 0);
      push_ent(32'h40C00000, 6, 1);
      ent_valid = 0;
      sb.push_back('{32'h40800000, 2, 0, 32'h40A00000, 3, 1, 32'h3F000000});
      sb.push_back('{32'h40C00000, 6, 0, 0, 0, 1, 32'h3F000000});
      give_vec(32'h3F000000);
      wait_done(2);
      // empty column then one-entry column, vector fetched per column
      start_job(2);
      push_ent(0, 0, 1);
      push_ent(32'h41000000, 7, 1);
      ent_valid = 0;
      sb.push_back('{0, 0, 0, 0, 0, 1, 32'h12345678});
      sb.push_back('{32'h41000000, 7, 1, 0, 0, 1, 32'h9ABCDEF0});
      give_vec(32'h12345678);
      give_vec(32'h9ABCDEF0);
      wait_done(2);
      // zero-column job finishes immediately
      start_job(0);
      chk("zero_done", done, 1);
      chk("zero_vec_ready", vec_ready, 0);
      chk("zero_out_valid", out_valid, 0);
      chk("zero_pairs", pairs_emitted, 0);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
      chk("zero_busy", busy, 0);
      // backpressure while stalled waiting for the vector
      start_job(2);
      push_ent(32'h3F800000, 10, 0);
      push_ent(32'h40000000, 11, 0);
      push_ent(32'h40400000, 12, 0);
      chk("ready_below_full", ent_ready, 1);
      push_ent(32'h40800000, 13, 1);
      chk("ready_at_full", ent_ready, 0);
      @(negedge clk);
      chk("ready_held_full", ent_ready, 0);
      sb.push_back('{32'h3F800000, 10, 0, 32'h40000000, 11, 1, 32'h55});
      sb.push_back('{32'h40400000, 12, 0, 32'h40800000, 13, 1, 32'h55});
      sb.push_back('{32'h40A00000, 14, 0, 0, 0, 1, 32'h66});
      fork
         push_ent(32'h40A00000, 14, 1);
         give_vec(32'h55);
      join
      ent_valid = 0;
      give_vec(32'h66);
      wait_done(3);
      // reset while stalled in lane-2 fill
      start_job(1);
      push_ent(32'h3F800000, 1, 0);
      ent_valid = 0;
      give_vec(32'h77);
      repeat (3) @(negedge clk);
      chk("stall_busy", busy, 1);
      chk("stall_out_valid", out_valid, 0);
      reset = 1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_vec", vec, 0);
      chk("mid_rst_pairs", pairs_emitted, 0);
      chk("mid_rst_val1", val1, 0);
      chk("mid_rst_rowIdx1", rowIdx1, 0);
      chk("mid_rst_ent_ready", ent_ready, 0);
      chk("mid_rst_vec_ready", vec_ready, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      start_job(1);
      push_ent(32'h3F800000, 8, 0);
      push_ent(32'h40000000, 9, 1);
      ent_valid = 0;
      sb.push_back('{32'h3F800000, 8, 0, 32'h40000000, 9, 1, 32'h40400000});
      give_vec(32'h40400000);
      wait_done(1);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
